// File: rtl/acc_ctrl.sv
// Accumulator sequencing controller: accepts one operation per handshake, executes
// single-cycle ALU ops in EXEC or a shift-add multiply in MUL, and owns acc/flags.
module acc_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t               state, next_state;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   product;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 mul_last;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     exec_res;
    logic                 exec_c;
    logic                 exec_wr;

    assign mul_last = (cnt == CNT_W'(WIDTH));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        op_ready   = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
                if (op_valid) begin
                    accept     = 1'b1;
                    next_state = (op_code == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC:  next_state = S_IDLE;
            S_MUL:   if (mul_last) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Single-cycle result; A is the current accumulator, B the latched operand.
    always_comb begin
        sum      = {1'b0, acc_out} + {1'b0, b_q};
        exec_res = acc_out;
        exec_c   = flag_c;
        exec_wr  = 1'b1;
        case (op_q)
            OP_LOAD: exec_res = b_q;
            OP_ADD:  {exec_c, exec_res} = sum;
            OP_SUB: begin
                exec_res = acc_out - b_q;
                exec_c   = (b_q > acc_out);
            end
            OP_AND:  exec_res = acc_out & b_q;
            OP_OR:   exec_res = acc_out | b_q;
            OP_CLR: begin
                exec_res = '0;
                exec_c   = 1'b0;
            end
            default: exec_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_out <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
            done    <= 1'b0;
            op_q    <= OP_NOP;
            b_q     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            product <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q    <= op_code;
                b_q     <= operand;
                mplier  <= operand;
                mcand   <= {{WIDTH{1'b0}}, acc_out};
                product <= '0;
                cnt     <= '0;
            end
            case (state)
                S_EXEC: begin
                    done <= 1'b1;
                    if (exec_wr) begin
                        acc_out <= exec_res;
                        flag_c  <= exec_c;
                        flag_z  <= (exec_res == '0);
                        flag_n  <= exec_res[WIDTH-1];
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        acc_out <= product[WIDTH-1:0];
                        flag_c  <= |product[2*WIDTH-1:WIDTH];
                        flag_z  <= (product[WIDTH-1:0] == '0);
                        flag_n  <= product[WIDTH-1];
                        done    <= 1'b1;
                    end else begin
                        // One multiplier bit per edge, LSB first.
                        if (mplier[0]) product <= product + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_acc_ctrl;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [W-1:0]  operand;
    logic [W-1:0]  acc_out;
    logic          flag_z, flag_c, flag_n;
    logic          busy, done;

    acc_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .operand(operand), .acc_out(acc_out),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain unsigned arithmetic on integers.
    logic [W-1:0] m_acc;
    logic         m_z, m_c, m_n;

    task automatic model_reset();
        m_acc = '0; m_z = 0; m_c = 0; m_n = 0;
    endtask

    task automatic model_op(input logic [2:0] op, input logic [W-1:0] b);
        longint unsigned a, bb, r, p;
        bit wr;
        a = longint'(m_acc); bb = longint'(b); r = a; wr = 1;
        case (op)
            3'd0: wr = 0;
            3'd1: r = bb;
            3'd2: begin r = (a + bb) % 65536; m_c = (a + bb) > 65535; end
            3'd3: begin r = (a + 65536 - bb) % 65536; m_c = bb > a; end
            3'd4: r = a & bb;
            3'd5: r = a | bb;
            3'd6: begin p = a * bb; r = p % 65536; m_c = p > 65535; end
            default: begin r = 0; m_c = 0; end
        endcase
        if (wr) begin
            m_acc = 16'(r);
            m_z   = (r == 0);
            m_n   = (r >= 32768);
        end
    endtask

    // Issue one op from IDLE; returns edges from accept to done (40 = timeout).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] b, output int lat);
        op_valid = 1'b1; op_code = op; operand = b;
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = 3'($urandom); operand = 16'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] b;
        logic [W-1:0] acc;
        logic [2:0]   zcn;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int done_cnt;
        logic [2:0] rop;
        logic [W-1:0] rb;

        vecs.push_back('{3'd1, 16'h0005, 16'h0005, 3'b000, 1});
        vecs.push_back('{3'd2, 16'h0003, 16'h0008, 3'b000, 1});
        vecs.push_back('{3'd1, 16'hFFFF, 16'hFFFF, 3'b001, 1});
        vecs.push_back('{3'd2, 16'h0002, 16'h0001, 3'b010, 1});
        vecs.push_back('{3'd3, 16'h0001, 16'h0000, 3'b100, 1});
        vecs.push_back('{3'd1, 16'h0003, 16'h0003, 3'b000, 1});
        vecs.push_back('{3'd3, 16'h0005, 16'hFFFE, 3'b011, 1});
        vecs.push_back('{3'd4, 16'h00F0, 16'h00F0, 3'b010, 1});
        vecs.push_back('{3'd5, 16'h0F0F, 16'h0FFF, 3'b010, 1});
        vecs.push_back('{3'd0, 16'h1234, 16'h0FFF, 3'b010, 1});
        vecs.push_back('{3'd7, 16'hABCD, 16'h0000, 3'b100, 1});
        vecs.push_back('{3'd1, 16'h0123, 16'h0123, 3'b000, 1});
        vecs.push_back('{3'd6, 16'h0010, 16'h1230, 3'b000, 17});
        vecs.push_back('{3'd1, 16'h1000, 16'h1000, 3'b000, 1});
        vecs.push_back('{3'd6, 16'h0020, 16'h0000, 3'b110, 17});

        // Reset, with a simultaneous request that must lose to reset.
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; operand = '0;
        repeat (2) @(posedge clk);
        #1;
        op_valid = 1'b1; op_code = 3'd1; operand = 16'h0055;
        @(posedge clk); #1;
        reset = 1'b0; op_valid = 1'b0;
        model_reset();
        check("reset_acc", 32'(acc_out), 32'h0);
        check("reset_flags", 32'({flag_z, flag_c, flag_n}), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_ready", 32'(op_ready), 32'h1);

        // Directed vector table.
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].b, lat);
            model_op(vecs[i].op, vecs[i].b);
            check($sformatf("vec%0d_acc", i), 32'(acc_out), 32'(vecs[i].acc));
            check($sformatf("vec%0d_zcn", i), 32'({flag_z, flag_c, flag_n}), 32'(vecs[i].zcn));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // MUL with op_valid pulses that must be ignored; acc holds its old value.
        issue(3'd1, 16'h0123, lat);
        model_op(3'd1, 16'h0123);
        op_valid = 1'b1; op_code = 3'd6; operand = 16'h0010;
        @(posedge clk); #1;
        op_valid = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            op_valid = lat[0]; op_code = 3'd1; operand = 16'hDEAD;
            @(posedge clk); #1;
            lat++;
            if (!done) begin
                check("mul_ready_low", 32'(op_ready), 32'h0);
                check("mul_busy", 32'(busy), 32'h1);
                check("mul_acc_hold", 32'(acc_out), 32'h0123);
            end
        end
        op_valid = 1'b0;
        model_op(3'd6, 16'h0010);
        check("mul_lat", 32'(lat), 32'd17);
        check("mul_acc", 32'(acc_out), 32'h1230);
        check("mul_ready_done", 32'(op_ready), 32'h1);
        check("mul_busy_done", 32'(busy), 32'h0);
        done_cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            done_cnt += int'(done);
        end
        check("mul_no_queued", 32'(done_cnt), 32'd0);
        check("mul_acc_after", 32'(acc_out), 32'h1230);

        // Reset in the middle of a multiply.
        issue(3'd1, 16'h0007, lat);
        model_op(3'd1, 16'h0007);
        op_valid = 1'b1; op_code = 3'd6; operand = 16'h0003;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check("abort_acc", 32'(acc_out), 32'h0);
        check("abort_flags", 32'({flag_z, flag_c, flag_n}), 32'h0);
        check("abort_ready", 32'(op_ready), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        done_cnt = int'(done);
        repeat (20) begin
            @(posedge clk); #1;
            done_cnt += int'(done);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Held op_valid: one ADD accepted every two cycles.
        issue(3'd7, 16'h0000, lat);
        model_op(3'd7, 16'h0000);
        op_valid = 1'b1; op_code = 3'd2; operand = 16'h0001;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (e % 2 == 1) begin
                check($sformatf("b2b_done_e%0d", e), 32'(done), 32'h0);
            end else begin
                check($sformatf("b2b_done_e%0d", e), 32'(done), 32'h1);
                check($sformatf("b2b_acc_e%0d", e), 32'(acc_out), 32'(e / 2));
                model_op(3'd2, 16'h0001);
            end
        end
        op_valid = 1'b0;
        check("b2b_flags", 32'({flag_z, flag_c, flag_n}), 32'({m_z, m_c, m_n}));
        @(posedge clk); #1;

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            rb  = (k % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            issue(rop, rb, lat);
            model_op(rop, rb);
            check($sformatf("rnd%0d_op%0d_acc", k, rop), 32'(acc_out), 32'(m_acc));
            check($sformatf("rnd%0d_op%0d_zcn", k, rop), 32'({flag_z, flag_c, flag_n}),
                  32'({m_z, m_c, m_n}));
            check($sformatf("rnd%0d_lat", k), 32'(lat), (rop == 3'd6) ? 32'd17 : 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
